// File: rtl/channel_sample_sequencer_if.sv
// channel_sample_sequencer_if
//   Output stream of the channel sample sequencer: one tagged sample per beat on a
//   valid/ready handshake.
//   Handshake: the master raises out_valid with out_data/out_channel/frame flags and
//   holds them unchanged while out_valid && !out_ready; a beat transfers on any
//   clock edge where out_valid && out_ready.
//   Signals:
//     out_data        sample value
//     out_channel     channel index of out_data
//     out_frame_start out_data belongs to channel 0 (qualified by out_valid)
//     out_frame_end   out_data belongs to the last channel (qualified by out_valid)
//     out_valid       out_* hold a sample
//     out_ready       consumer accepts the beat
interface channel_sample_sequencer_if #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int CH_W         = 4
);
  logic [SAMPLE_WIDTH-1:0] out_data;
  logic [CH_W-1:0]         out_channel;
  logic                    out_frame_start;
  logic                    out_frame_end;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output out_data, out_channel, out_frame_start, out_frame_end, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_channel, out_frame_start, out_frame_end, out_valid,
    output out_ready
  );
endinterface

// File: rtl/channel_sample_sequencer.sv
// channel_sample_sequencer
//   Paces samples from sample_in with a programmable tick divider, tags each with a
//   round-robin channel index and frame markers, and presents them on a valid/ready
//   stream. A tick that finds the output slot occupied and not being drained drops
//   its sample; drops are counted (saturating) and flagged by a sticky overrun bit.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     enable        run request; dropping it finishes the current frame first
//     div           tick period minus one (0 = tick every cycle)
//     sample_in     raw sample captured on each tick
//     out_if        output stream (master side of channel_sample_sequencer_if)
//     clear_ovr     synchronous clear of overrun and drop_count
//     overrun       sticky: at least one sample dropped
//     drop_count    number of dropped samples, saturating at all-ones
//     busy          running, or a sample is still waiting to be delivered
//     state_dbg_o   FSM state (0 = IDLE, 1 = RUN)
module channel_sample_sequencer #(
  parameter int NUM_CHANNELS   = 14,
  parameter int SAMPLE_WIDTH   = 8,
  parameter int DIV_WIDTH      = 24,
  parameter int DROP_CNT_WIDTH = 8,
  localparam int CH_W          = $clog2(NUM_CHANNELS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          div,
  input  logic [SAMPLE_WIDTH-1:0]       sample_in,
  channel_sample_sequencer_if.master    out_if,
  input  logic                          clear_ovr,
  output logic                          overrun,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count,
  output logic                          busy,
  output logic                          state_dbg_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [DIV_WIDTH-1:0]      cnt_q, cnt_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [SAMPLE_WIDTH-1:0]   data_q, data_d;
  logic [CH_W-1:0]           och_q, och_d;
  logic                      valid_q, valid_d;
  logic                      ovr_q, ovr_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic tick;
  logic last_ch;
  logic xfer;
  logic drop;

  // >= rather than == so that lowering div below the running count still
  // produces a tick on the very next cycle instead of waiting for wrap-around.
  assign tick    = (state_q == ST_RUN) && (cnt_q >= div);
  assign last_ch = (ch_q == CH_W'(NUM_CHANNELS - 1));
  assign xfer    = valid_q && out_if.out_ready;
  // The slot is free for a new sample if empty or leaving in this same cycle.
  assign drop    = tick && valid_q && !out_if.out_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (tick && last_ch && !enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = '0;
    ch_d    = '0;
    data_d  = data_q;
    och_d   = och_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    drop_d  = drop_q;

    // Counter and channel index only move in RUN; leaving RUN always happens on
    // the last-channel tick, so the index is already wrapping to 0 there.
    if (state_q == ST_RUN) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
      if (tick) begin
        ch_d = last_ch ? '0 : ch_q + CH_W'(1);
      end else begin
        ch_d = ch_q;
      end
    end

    if (tick && !drop) begin
      data_d  = sample_in;
      och_d   = ch_q;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    // A drop in the same cycle as clear_ovr is counted after the clear.
    if (clear_ovr) begin
      ovr_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovr_d = 1'b1;
      if (clear_ovr) begin
        drop_d = DROP_CNT_WIDTH'(1);
      end else if (drop_q != {DROP_CNT_WIDTH{1'b1}}) begin
        drop_d = drop_q + DROP_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      och_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      och_q   <= och_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      drop_q  <= drop_d;
    end
  end

  assign out_if.out_data        = data_q;
  assign out_if.out_channel     = och_q;
  assign out_if.out_valid       = valid_q;
  assign out_if.out_frame_start = valid_q && (och_q == '0);
  assign out_if.out_frame_end   = valid_q && (och_q == CH_W'(NUM_CHANNELS - 1));

  assign overrun     = ovr_q;
  assign drop_count  = drop_q;
  // A sample still waiting after RUN->IDLE keeps the block busy until delivered.
  assign busy        = (state_q == ST_RUN) || valid_q;
  assign state_dbg_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_channel_sample_sequencer.sv
module tb_channel_sample_sequencer;
  localparam int N   = 14;
  localparam int SW  = 8;
  localparam int DW  = 24;
  localparam int CW  = 8;
  localparam int CHW = 4;
  localparam int DROP_MAX = 255;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] div = '0;
  logic [SW-1:0] sample_in = '0;
  logic          ready = 1'b0;
  logic          clear_ovr = 1'b0;
  logic          overrun;
  logic [CW-1:0] drop_count;
  logic          busy;
  logic          state_dbg;

  always #5 clk = ~clk;

  channel_sample_sequencer_if #(.SAMPLE_WIDTH(SW), .CH_W(CHW)) bus ();
  assign bus.out_ready = ready;

  channel_sample_sequencer #(
    .NUM_CHANNELS(N), .SAMPLE_WIDTH(SW), .DIV_WIDTH(DW), .DROP_CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .div(div),
    .sample_in(sample_in),
    .out_if(bus),
    .clear_ovr(clear_ovr),
    .overrun(overrun),
    .drop_count(drop_count),
    .busy(busy),
    .state_dbg_o(state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // ---------------- behavioural reference model ----------------
  // Ticks are counted since RUN entry; the channel of a capture is simply the
  // tick number modulo N. The output slot holds at most one sample.
  bit m_run;
  int m_since;
  int m_tickn;
  bit m_valid;
  int m_data;
  int m_ch;
  bit m_ovr;
  int m_drops;
  int last_xfer_ch;

  task automatic model_reset();
    m_run = 0; m_since = 0; m_tickn = 0;
    m_valid = 0; m_data = 0; m_ch = 0;
    m_ovr = 0; m_drops = 0;
  endtask

  task automatic model_next();
    bit tick;
    bit drop;
    int ch;
    ch   = m_tickn % N;
    tick = m_run && (m_since >= int'(div));
    drop = tick && m_valid && !ready;
    if (m_valid && ready) last_xfer_ch = m_ch;
    if (tick && !drop) begin
      m_valid = 1; m_data = int'(sample_in); m_ch = ch;
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    if (clear_ovr) begin
      m_ovr = 0; m_drops = 0;
    end
    if (drop) begin
      m_ovr = 1;
      if (m_drops < DROP_MAX) m_drops++;
    end
    if (!m_run) begin
      m_run = enable; m_since = 0; m_tickn = 0;
    end else if (tick) begin
      if (ch == N - 1 && !enable) m_run = 0;
      m_since = 0;
      m_tickn++;
    end else begin
      m_since++;
    end
  endtask

  task automatic compare();
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(bus.out_data), 32'(m_data));
      chk("out_channel", 32'(bus.out_channel), 32'(m_ch));
    end
    chk("frame_start", 32'(bus.out_frame_start), 32'(m_valid && m_ch == 0));
    chk("frame_end", 32'(bus.out_frame_end), 32'(m_valid && m_ch == N - 1));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    chk("busy", 32'(busy), 32'(m_run || m_valid));
    chk("state", 32'(state_dbg), 32'(m_run));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are compared on
  // the falling edge, then the model advances for the coming rising edge.
  task automatic step();
    @(negedge clk);
    compare();
    model_next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_mid(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rst_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_rst_channel"}, 32'(bus.out_channel), 32'd0);
    chk({tag, "_rst_fs"}, 32'(bus.out_frame_start), 32'd0);
    chk({tag, "_rst_fe"}, 32'(bus.out_frame_end), 32'd0);
    chk({tag, "_rst_ovr"}, 32'(overrun), 32'd0);
    chk({tag, "_rst_drops"}, 32'(drop_count), 32'd0);
    chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rst_state"}, 32'(state_dbg), 32'd0);
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit hit;
    model_reset();
    last_xfer_ch = -1;
    @(posedge clk);
    #1;
    reset_mid("init");

    // Reset mid-frame at channel 5 with a sample pending.
    div = 0; ready = 0; enable = 1;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      ready = (m_ch < 5) ? 1'b1 : 1'b0;
      hit = m_valid && m_ch == 5;
    end
    chk("t1_reach_ch5", 32'(hit), 32'd1);
    chk("t1_pending", 32'(bus.out_valid), 32'd1);
    reset_mid("t1");
    ready = 1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = m_valid;
    end
    chk("t1_first_after_rst", 32'(bus.out_channel), 32'd0);

    // div=3, continuous ready, sample_in follows the cycle counter.
    enable = 0;
    reset_mid("t2");
    div = 3; ready = 1; enable = 1;
    for (int i = 0; i < 2 * N * 4 + 10; i++) begin
      sample_in = SW'(cyc);
      step();
    end

    // div=0: a sample every cycle, no overrun.
    enable = 0;
    reset_mid("t3");
    div = 0; ready = 1; enable = 1;
    for (int i = 0; i < 40; i++) begin
      sample_in = SW'($urandom);
      step();
    end
    chk("t3_valid_cont", 32'(bus.out_valid), 32'd1);
    chk("t3_no_ovr", 32'(overrun), 32'd0);

    // Lower div below the running count: the tick must come on the next cycle.
    div = 20;
    for (int i = 0; i < 12; i++) step();
    div = 2;
    for (int i = 0; i < 10; i++) step();

    // div=1, ready held low 10 cycles after the first capture.
    enable = 0;
    reset_mid("t4");
    div = 1; ready = 0; enable = 1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      sample_in = SW'($urandom);
      step();
      hit = m_valid;
    end
    chk("t4_first", 32'(hit), 32'd1);
    for (int i = 0; i < 10; i++) begin
      sample_in = SW'($urandom);
      step();
    end
    chk("t4_frozen_ch", 32'(bus.out_channel), 32'd0);
    chk("t4_drops", 32'(drop_count), 32'd5);
    chk("t4_ovr", 32'(overrun), 32'd1);
    ready = 1;
    step();
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step();
      hit = m_valid;
    end
    chk("t4_next_ch", 32'(bus.out_channel), 32'd6);

    // Saturating drop counter, then clear with a coincident drop.
    enable = 0;
    reset_mid("t5");
    div = 0; ready = 0; enable = 1;
    for (int i = 0; i < 305; i++) step();
    chk("t5_sat", 32'(drop_count), 32'd255);
    clear_ovr = 1;
    step();
    clear_ovr = 0;
    chk("t5_clr_drop_cnt", 32'(drop_count), 32'd1);
    chk("t5_clr_drop_ovr", 32'(overrun), 32'd1);
    step();

    // enable dropped at channel 3: finish the frame, deliver, then idle.
    enable = 0;
    reset_mid("t6");
    div = 1; ready = 1; enable = 1;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      sample_in = SW'($urandom);
      step();
      hit = m_run && (m_tickn % N == 3) && m_tickn > N;
    end
    chk("t6_reach_ch3", 32'(hit), 32'd1);
    enable = 0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      hit = !m_run && !m_valid;
    end
    chk("t6_idle", 32'(hit), 32'd1);
    chk("t6_last_ch", 32'(last_xfer_ch), 32'd13);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cnt", 32'(dut.cnt_q), 32'd0);
    for (int i = 0; i < 5; i++) step();

    // Randomised traffic against the model.
    reset_mid("rnd");
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) div = DW'($urandom_range(0, 3));
      ready     = ($urandom_range(0, 3) != 0);
      clear_ovr = ($urandom_range(0, 29) == 0);
      sample_in = SW'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
